core_ctl: RTL and testbench
===========================

# core_ctl

Multi-cycle sequencer for the core. Owns the 3-bit `state` that drives decode and the rest of the datapath, and holds the program counter. It performs the memory handshakes for instruction fetch and data access, skips the MEM phase for non-memory instructions, applies branch/jump outcomes at WRITE, and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- run  in  1  enable; FETCH issues a request only while high.
- imem_ack  in  1  instruction memory done; instruction word valid this cycle.
- dmem_ack  in  1  data memory done; load data valid this cycle.
- mem_read  in  1  decoded load flag, registered by decode at DECODE.
- mem_write  in  1  decoded store flag, registered by decode at DECODE.
- reg_write  in  1  decoded register-write flag.
- branch_uc  in  1  decoded unconditional jump (jal/jalr).
- branch_c  in  1  decoded conditional branch.
- cond  in  1  ALU compare result (bge true), valid from EXEC.
- target  in  32  branch/jump target, valid from EXEC.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
- pc  out  32  current instruction address.
- imem_req  out  1  fetch request.
- ir_write  out  1  latch instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a store; valid only with dmem_req.
- rf_we  out  1  register file write strobe.
- instret  out  INSTRET_W  retired-instruction count.

## Operation
- FETCH (0): imem_req = run. Stays in FETCH until imem_ack && run. On that cycle: ir_write = 1 and next state is DECODE. An imem_ack while run = 0 is ignored.
- DECODE (1): one cycle. Decode registers its flags at this edge. Next state is EXEC.
- EXEC (2): one cycle. Next state is MEM if (mem_read || mem_write), otherwise WRITE.
- MEM (3): dmem_req = 1 and dmem_we = mem_write. Stays in MEM until dmem_ack, then goes to WRITE.
- WRITE (4): one cycle.
  - rf_we = reg_write.
  - taken = branch_uc || (branch_c && cond).
  - pc <= taken ? target : pc + 4, with 32-bit wrap.
  - instret <= instret + 1, wraps modulo 2^INSTRET_W.
  - Next state is FETCH.
- Encodings 5–7 are unreachable. If entered, the next state is FETCH with pc unchanged.
- imem_req, ir_write, dmem_req, dmem_we and rf_we are combinational decodes of the current state and inputs. They are never asserted outside their own state.
- pc and instret change only in WRITE.

## Timing
- Reset (rstn low, asynchronous):
  - state = FETCH, pc = RESET_PC, instret = 0.
  - imem_req = ir_write = dmem_req = dmem_we = rf_we = 0.
  - Release is synchronous to the next posedge. The first imem_req is asserted in the first cycle after release if run = 1.
- Reset mid-transaction: any pending request is dropped immediately; no write or retire happens. A late ack arriving after reset is treated as a normal FETCH ack only if run = 1 and state = FETCH.
- Minimum latency with zero-wait memory:
  - ALU/branch instruction: 4 cycles (F, D, E, W).
  - Load/store: 5 cycles.
  - Each wait cycle on an ack adds exactly one cycle.
- imem_req and dmem_req stay asserted continuously until their ack. An ack in the same cycle the request first rises completes the phase in that cycle.
- pc holds the fetched instruction's address from FETCH through WRITE. It updates at the WRITE→FETCH edge.
- run dropping mid-instruction does not stall it. The instruction completes and the core then idles in FETCH.

## Test plan
- Reset then run = 1 with immediate imem_ack, instruction addi (reg_write = 1, no mem, no branch): states 0,1,2,4,0. rf_we high only in state 4. pc goes 0→4 and instret goes 0→1.
- Load with dmem_ack delayed 3 cycles: MEM lasts 4 cycles with dmem_req = 1 and dmem_we = 0 throughout. rf_we asserts once in WRITE. Total 8 cycles.
- Store: dmem_req = 1 and dmem_we = 1 in MEM. rf_we = 0 in WRITE. pc increments by 4.
- Branches:
  - bge with cond = 1, target = 0x40: pc = 0x40 after WRITE.
  - Same with cond = 0: pc = old + 4.
  - jal with target = 0x100: pc = 0x100 regardless of cond.
- run = 0 at FETCH with imem_ack pulsed: stays in FETCH, imem_req = 0, ir_write = 0, pc unchanged. Raise run with imem_ack: proceeds to DECODE.
- Wrap cases:
  - rstn asserted during MEM with dmem_req high: all outputs are at reset values in the same cycle, and instret is not incremented.
  - pc = 0xFFFF_FFFC non-branch: wraps to 0.
  - instret at all-ones: wraps to 0.

Source files
------------

// File: rtl/core_ctl.sv
// core_ctl: multi-cycle FETCH/DECODE/EXEC/MEM/WRITE sequencer.
// Holds the program counter and the retired-instruction counter.
module core_ctl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic                 branch_uc,
  input  logic                 branch_c,
  input  logic                 cond,
  input  logic [31:0]          target,
  output logic [2:0]           state,
  output logic [31:0]          pc,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = INSTRET_W'(1);

  logic [2:0]           state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 taken_s;

  // State, pc and retire counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic; encodings 5-7 fall back to FETCH.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: begin
        if (run && imem_ack) state_d = ST_DECODE;
        else                 state_d = ST_FETCH;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (mem_read || mem_write) state_d = ST_MEM;
        else                       state_d = ST_WRITE;
      end
      ST_MEM: begin
        if (dmem_ack) state_d = ST_WRITE;
        else          state_d = ST_MEM;
      end
      ST_WRITE: state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // pc and instret advance only when an instruction retires in WRITE.
  always_comb begin
    taken_s   = branch_uc || (branch_c && cond);
    pc_d      = pc_q;
    instret_d = instret_q;
    if (state_q == ST_WRITE) begin
      if (taken_s) pc_d = target;
      else         pc_d = pc_q + 32'd4;
      instret_d = instret_q + INSTRET_ONE;
    end else begin
      pc_d      = pc_q;
      instret_d = instret_q;
    end
  end

  // Strobe decode; gated by rstn so they drop the moment reset asserts.
  always_comb begin
    imem_req = 1'b0;
    ir_write = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    if (rstn) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = run;
          ir_write = run && imem_ack;
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
        end
        ST_WRITE: rf_we = reg_write;
        default: begin
          imem_req = 1'b0;
          dmem_req = 1'b0;
        end
      endcase
    end else begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_ctl.sv
// Directed self-checking bench for core_ctl (RESET_PC near the top of the
// address space and a 3-bit retire counter so both wraps are reachable).
module tb_core_ctl;
  logic        clk = 1'b0;
  logic        rstn, run, imem_ack, dmem_ack;
  logic        mem_read, mem_write, reg_write, branch_uc, branch_c, cond;
  logic [31:0] target;
  logic [2:0]  state;
  logic [31:0] pc;
  logic        imem_req, ir_write, dmem_req, dmem_we, rf_we;
  logic [2:0]  instret;

  int n_checks = 0;
  int n_errors = 0;

  core_ctl #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_W(3)) dut (
    .clk(clk), .rstn(rstn), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch_uc(branch_uc), .branch_c(branch_c), .cond(cond), .target(target),
    .state(state), .pc(pc), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One instruction with iw fetch wait cycles and dw data wait cycles.
  task automatic do_instr(input string tag, input int iw, input int dw,
                          input logic rd, input logic wr, input logic rw,
                          input logic buc, input logic bc, input logic cnd,
                          input logic [31:0] tgt, input logic [31:0] pc_before,
                          input logic [31:0] pc_after, input logic [2:0] ret_after,
                          input int exp_cyc);
    int ncyc = 0;
    run = 1'b1; mem_read = rd; mem_write = wr; reg_write = rw;
    branch_uc = buc; branch_c = bc; cond = cnd; target = tgt;
    for (int k = 0; k <= iw; k++) begin
      imem_ack = (k == iw);
      #1;
      check({tag, " F state"}, 32'(state), 32'd0);
      check({tag, " F imem_req"}, 32'(imem_req), 32'd1);
      check({tag, " F ir_write"}, 32'(ir_write), 32'(k == iw));
      check({tag, " F pc"}, pc, pc_before);
      tick(); ncyc++;
    end
    imem_ack = 1'b0;
    #1;
    check({tag, " D state"}, 32'(state), 32'd1);
    check({tag, " D strobes"}, {27'd0, imem_req, ir_write, dmem_req, dmem_we, rf_we}, 32'd0);
    tick(); ncyc++;
    check({tag, " E state"}, 32'(state), 32'd2);
    tick(); ncyc++;
    if (rd || wr) begin
      for (int k = 0; k <= dw; k++) begin
        dmem_ack = (k == dw);
        #1;
        check({tag, " M state"}, 32'(state), 32'd3);
        check({tag, " M dmem_req"}, 32'(dmem_req), 32'd1);
        check({tag, " M dmem_we"}, 32'(dmem_we), 32'(wr));
        check({tag, " M rf_we"}, 32'(rf_we), 32'd0);
        tick(); ncyc++;
      end
      dmem_ack = 1'b0;
    end
    #1;
    check({tag, " W state"}, 32'(state), 32'd4);
    check({tag, " W rf_we"}, 32'(rf_we), 32'(rw));
    check({tag, " W pc"}, pc, pc_before);
    check({tag, " W dmem_req"}, 32'(dmem_req), 32'd0);
    tick(); ncyc++;
    check({tag, " done state"}, 32'(state), 32'd0);
    check({tag, " done pc"}, pc, pc_after);
    check({tag, " done instret"}, 32'(instret), 32'(ret_after));
    check({tag, " cycles"}, 32'(ncyc), 32'(exp_cyc));
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    branch_uc = 1'b0; branch_c = 1'b0; cond = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    branch_uc = 1'b0; branch_c = 1'b0; cond = 1'b0; target = 32'd0;
    tick(); tick();
    check("rst state", 32'(state), 32'd0);
    check("rst pc", pc, 32'hFFFF_FFFC);
    check("rst instret", 32'(instret), 32'd0);
    check("rst strobes", {27'd0, imem_req, ir_write, dmem_req, dmem_we, rf_we}, 32'd0);
    imem_ack = 1'b0;
    rstn = 1'b1;
    #1;
    check("release imem_req", 32'(imem_req), 32'd1);
    check("release state", 32'(state), 32'd0);

    do_instr("addi_wrap", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 3'd1, 4);
    do_instr("addi", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004, 3'd2, 4);
    do_instr("load", 0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0008, 3'd3, 8);
    do_instr("store", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_000C, 3'd4, 5);
    do_instr("bge_t", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0000_000C, 32'h0000_0040, 3'd5, 4);
    do_instr("bge_nt", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0000_0040, 32'h0000_0044, 3'd6, 4);
    do_instr("jal", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0000_0044, 32'h0000_0100, 3'd7, 4);
    do_instr("ret_wrap", 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 32'h0000_0104, 3'd0, 6);

    // Acks while run is low must be ignored.
    run = 1'b0; imem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("idle imem_req", 32'(imem_req), 32'd0);
      check("idle ir_write", 32'(ir_write), 32'd0);
      tick();
      check("idle state", 32'(state), 32'd0);
      check("idle pc", pc, 32'h0000_0104);
    end
    do_instr("resume", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0104, 32'h0000_0108, 3'd1, 4);

    // Reset asserted in MEM with the data request pending.
    run = 1'b1; mem_read = 1'b1; reg_write = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    tick(); imem_ack = 1'b0;
    tick(); tick();
    check("pre-rst state", 32'(state), 32'd3);
    check("pre-rst dmem_req", 32'(dmem_req), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst state", 32'(state), 32'd0);
    check("midrst pc", pc, 32'hFFFF_FFFC);
    check("midrst instret", 32'(instret), 32'd0);
    check("midrst strobes", {27'd0, imem_req, ir_write, dmem_req, dmem_we, rf_we}, 32'd0);
    tick();
    rstn = 1'b1; dmem_ack = 1'b1;
    #1;
    check("late ack imem_req", 32'(imem_req), 32'd1);
    tick();
    check("late ack state", 32'(state), 32'd0);
    check("late ack instret", 32'(instret), 32'd0);
    dmem_ack = 1'b0;
    do_instr("post_rst", 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 3'd1, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
